// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: does the initial AddRoundKey, then steps one shared round unit through rounds 1..NUM_ROUNDS.
// Optional feature macro: AES_SEQ_ABORT_EN (adds the abort input).
module aes_round_sequencer #(
  parameter int ROUND_LAT  = 0,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef AES_SEQ_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [127:0]                  block_in,
  input  logic [128*(NUM_ROUNDS+1)-1:0] expanded_key,
  output logic [127:0]                  rnd_state,
  output logic [127:0]                  rnd_key,
  output logic                          rnd_last,
  input  logic [127:0]                  rnd_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [127:0]                  block_out,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid holds with stable block_out until out_ready.

  localparam int CNT_W  = $clog2(NUM_ROUNDS + 1);
  localparam int WAIT_W = 2;
  localparam int RK_W   = 128 * NUM_ROUNDS;

  // dbg_state encoding: 0 = IDLE, 1 = ROUND, 2 = HOLD
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e              r_fsm;
  state_e              w_fsm_nxt;
  logic [CNT_W-1:0]    r_round_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [127:0]        r_state_reg;
  logic [RK_W-1:0]     r_key;
  logic [127:0]        r_block_out;
  logic                r_out_valid;
  logic                w_accept;
  logic                w_sample;
  logic                w_final;
  logic                w_abort;

`ifdef AES_SEQ_ABORT_EN
  assign w_abort = abort && (r_fsm != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_accept  = 1'b0;
    w_sample  = 1'b0;
    w_final   = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (in_valid) begin
          w_accept  = 1'b1;
          w_fsm_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        w_sample = (r_wait_cnt == WAIT_W'(ROUND_LAT));
        w_final  = w_sample && (r_round_cnt == CNT_W'(NUM_ROUNDS));
        if (w_abort)      w_fsm_nxt = S_IDLE;
        else if (w_final) w_fsm_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_abort || out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Round key 0 is consumed at accept time, so only keys 1..NUM_ROUNDS are latched;
  // r_key[127:0] therefore holds round key 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_round_cnt <= '0;
      r_wait_cnt  <= '0;
      r_state_reg <= '0;
      r_key       <= '0;
      r_block_out <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state_reg <= block_in ^ expanded_key[127:0];
      r_key       <= expanded_key[128*(NUM_ROUNDS+1)-1:128];
      r_round_cnt <= CNT_W'(1);
      r_wait_cnt  <= '0;
    end else if (w_abort) begin
      r_round_cnt <= '0;
      r_wait_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else if (r_fsm == S_ROUND) begin
      if (!w_sample) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
        if (w_final) begin
          r_block_out <= rnd_result;
          r_out_valid <= 1'b1;
          r_round_cnt <= '0;
        end else begin
          r_state_reg <= rnd_result;
          r_round_cnt <= r_round_cnt + CNT_W'(1);
        end
      end
    end else if ((r_fsm == S_HOLD) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    rnd_key = r_key[127:0];
    if (r_fsm == S_ROUND) begin
      for (int r = 1; r <= NUM_ROUNDS; r++) begin
        if (r_round_cnt == CNT_W'(r)) rnd_key = r_key[128*(r-1) +: 128];
      end
    end
  end

  assign rnd_state = r_state_reg;
  assign rnd_last  = (r_fsm == S_ROUND) && (r_round_cnt == CNT_W'(NUM_ROUNDS));
  assign in_ready  = (r_fsm == S_IDLE);
  assign busy      = (r_fsm == S_ROUND) || (r_fsm == S_HOLD);
  assign out_valid = r_out_valid;
  assign block_out = r_block_out;
  assign dbg_state = r_fsm;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: ROUND_LAT=0 instance (AES or stub round unit) and ROUND_LAT=2 instance (stub).
`timescale 1ns/1ps
module tb_aes_round_sequencer;
  localparam int KW = 1408;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] block_in;
  logic [KW-1:0] ekey;
  logic iv0, ir0, rl0, ov0, or0, busy0;
  logic iv2, ir2, rl2, ov2, or2, busy2;
  logic [127:0] rs0, rk0, rr0, bo0;
  logic [127:0] rs2, rk2, rr2, bo2;
  logic [1:0] dbg0, dbg2;
`ifdef AES_SEQ_ABORT_EN
  logic abort0, abort2;
`endif
  logic use_aes;
  logic sel;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] sbox_t [256];

  aes_round_sequencer #(.ROUND_LAT(0), .NUM_ROUNDS(10)) u_dut0 (
    .clk(clk), .reset(reset),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort0),
`endif
    .in_valid(iv0), .in_ready(ir0), .block_in(block_in), .expanded_key(ekey),
    .rnd_state(rs0), .rnd_key(rk0), .rnd_last(rl0), .rnd_result(rr0),
    .out_valid(ov0), .out_ready(or0), .block_out(bo0), .busy(busy0), .dbg_state(dbg0)
  );

  aes_round_sequencer #(.ROUND_LAT(2), .NUM_ROUNDS(10)) u_dut2 (
    .clk(clk), .reset(reset),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort2),
`endif
    .in_valid(iv2), .in_ready(ir2), .block_in(block_in), .expanded_key(ekey),
    .rnd_state(rs2), .rnd_key(rk2), .rnd_last(rl2), .rnd_result(rr2),
    .out_valid(ov2), .out_ready(or2), .block_out(bo2), .busy(busy2), .dbg_state(dbg2)
  );

  // ---------------- reference AES pieces ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k, input logic last);
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [7:0] m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) t[i] = sbox_t[st[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) u[r+4*c] = t[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = gmul(8'h02, u[4*c]) ^ gmul(8'h03, u[4*c+1]) ^ u[4*c+2] ^ u[4*c+3];
      m[4*c+1] = u[4*c] ^ gmul(8'h02, u[4*c+1]) ^ gmul(8'h03, u[4*c+2]) ^ u[4*c+3];
      m[4*c+2] = u[4*c] ^ u[4*c+1] ^ gmul(8'h02, u[4*c+2]) ^ gmul(8'h03, u[4*c+3]);
      m[4*c+3] = gmul(8'h03, u[4*c]) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(8'h02, u[4*c+3]);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = last ? u[i] : m[i];
    return o ^ k;
  endfunction

  function automatic logic [KW-1:0] expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [KW-1:0] ek;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ek[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ek;
  endfunction

  function automatic logic [KW-1:0] stub_key(input logic [7:0] base);
    logic [KW-1:0] ek;
    logic [7:0] b;
    for (int r = 0; r < 11; r++) begin
      b = 8'(r) + base;
      ek[128*r +: 128] = {16{b}};
    end
    return ek;
  endfunction

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] ek;
    for (int i = 0; i < 44; i++) ek[32*i +: 32] = $urandom;
    return ek;
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stub round unit is state ^ key, so the whole encryption is the XOR of the block and all 11 keys.
  function automatic logic [127:0] stub_model(input logic [127:0] blk, input logic [KW-1:0] ek);
    logic [127:0] acc;
    acc = blk;
    for (int r = 0; r < 11; r++) acc = acc ^ ek[128*r +: 128];
    return acc;
  endfunction

  // ---------------- round units ----------------
  always_comb rr0 = use_aes ? aes_round(rs0, rk0, rl0) : (rs0 ^ rk0);

  logic [127:0] p1, p2;
  always @(posedge clk) begin
    p1 <= rs2 ^ rk2;
    p2 <= p1;
  end
  assign rr2 = p2;

  // ---------------- selected-DUT views and drivers ----------------
  logic ov_s, ir_s, rl_s, busy_s;
  logic [127:0] rk_s, bo_s;
  logic [1:0] dbg_s;
  assign ov_s   = sel ? ov2 : ov0;
  assign ir_s   = sel ? ir2 : ir0;
  assign rl_s   = sel ? rl2 : rl0;
  assign busy_s = sel ? busy2 : busy0;
  assign rk_s   = sel ? rk2 : rk0;
  assign bo_s   = sel ? bo2 : bo0;
  assign dbg_s  = sel ? dbg2 : dbg0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_iv(input logic v);
    if (sel) iv2 = v; else iv0 = v;
  endtask

  task automatic drive_or(input logic v);
    if (sel) or2 = v; else or0 = v;
  endtask

  // One full transaction on the selected DUT, with optional backpressure and ignored in_valid noise.
  task automatic run_block(input string name, input logic [127:0] blk, input logic [KW-1:0] ek,
                           input logic [127:0] exp, input int lat_cfg, input int hold, input bit noise);
    logic [127:0] keys_q [$];
    logic last_q [$];
    int lat, per, rnd;
    per = lat_cfg + 1;
    n_tests++;
    if (ir_s !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before_accept got %b exp 1", name, ir_s);
    end
    block_in = blk; ekey = ek; drive_iv(1'b1);
    tick;
    drive_iv(1'b0);
    block_in = rand_blk(); ekey = rand_key();
    lat = 0;
    while (ov_s !== 1'b1 && lat < 200) begin
      keys_q.push_back(rk_s);
      last_q.push_back(rl_s);
      if (noise) drive_iv(1'($urandom_range(0, 1)));
      tick;
      lat++;
    end
    drive_iv(1'b0);
    n_tests++;
    if (lat != 10 * per) begin
      n_fail++; $display("FAIL %s latency got %0d exp %0d", name, lat, 10 * per);
    end
    for (int j = 0; j < keys_q.size() && j < 10 * per; j++) begin
      rnd = j / per + 1;
      n_tests++;
      if (keys_q[j] !== ek[128*rnd +: 128] || last_q[j] !== (rnd == 10)) begin
        n_fail++;
        $display("FAIL %s round_key cyc %0d got %h/%b exp %h/%b", name, j, keys_q[j], last_q[j],
                 ek[128*rnd +: 128], (rnd == 10));
      end
    end
    n_tests++;
    if (bo_s !== exp) begin
      n_fail++; $display("FAIL %s block_out got %h exp %h", name, bo_s, exp);
    end
    for (int h = 0; h <= hold; h++) begin
      n_tests++;
      if ({ov_s, ir_s, busy_s, rl_s} !== 4'b1010 || bo_s !== exp || dbg_s !== 2'd2) begin
        n_fail++;
        $display("FAIL %s hold cyc %0d got ov/ir/busy/last=%b%b%b%b out=%h exp 1010 out=%h", name, h,
                 ov_s, ir_s, busy_s, rl_s, bo_s, exp);
      end
      if (h < hold) begin
        if (noise) begin
          drive_iv(1'b1); block_in = rand_blk();
        end
        tick;
      end
    end
    drive_iv(1'b0);
    drive_or(1'b1);
    tick;
    drive_or(1'b0);
    n_tests++;
    if ({ov_s, ir_s, busy_s} !== 3'b010) begin
      n_fail++; $display("FAIL %s release got ov/ir/busy=%b%b%b exp 010", name, ov_s, ir_s, busy_s);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      #0;
      n_tests++;
      if ({ir_s, ov_s, busy_s, rl_s} !== 4'b1000 || bo_s !== 128'h0 || rk_s !== 128'h0 ||
          (sel ? rs2 : rs0) !== 128'h0 || dbg_s !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got ir/ov/busy/last=%b%b%b%b out=%h key=%h exp 1000 zeros",
                 d * 2, ir_s, ov_s, busy_s, rl_s, bo_s, rk_s);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_fips;
    sel = 1'b0; use_aes = 1'b1;
    run_block("fips", FIPS_PT, expand_key(FIPS_KEY), FIPS_CT, 0, 0, 1'b0);
  endtask

  task automatic test_stub(input logic s, input int lat_cfg);
    logic [KW-1:0] ek;
    logic [127:0] blk;
    sel = s; use_aes = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ek = (i == 0) ? stub_key(8'h00) : rand_key();
      blk = rand_blk();
      run_block(lat_cfg == 0 ? "stub_lat0" : "stub_lat2", blk, ek, stub_model(blk, ek), lat_cfg, 0, 1'b0);
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [KW-1:0] ek;
    logic [127:0] blk;
    use_aes = 1'b0;
    sel = 1'b0; ek = stub_key(8'h00); blk = rand_blk();
    run_block("bp_lat0", blk, ek, stub_model(blk, ek), 0, 5, 1'b1);
    sel = 1'b1; ek = rand_key(); blk = rand_blk();
    run_block("bp_lat2", blk, ek, stub_model(blk, ek), 2, 3, 1'b1);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    int t_q [$];
    int w;
    logic [KW-1:0] ek;
    logic [127:0] blk, exp;
    sel = 1'b0; use_aes = 1'b0;
    ek = rand_key(); blk = rand_blk(); exp = stub_model(blk, ek);
    block_in = blk; ekey = ek; iv0 = 1'b1; or0 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (ov0 === 1'b1) begin
        t_q.push_back(c);
        n_tests++;
        if (bo0 !== exp) begin
          n_fail++; $display("FAIL b2b block_out got %h exp %h", bo0, exp);
        end
      end
    end
    iv0 = 1'b0;
    n_tests++;
    if (t_q.size() < 3) begin
      n_fail++; $display("FAIL b2b completions got %0d exp 3", t_q.size());
    end
    for (int i = 1; i < t_q.size(); i++) begin
      n_tests++;
      if (t_q[i] - t_q[i-1] != 12) begin
        n_fail++; $display("FAIL b2b period got %0d exp 12", t_q[i] - t_q[i-1]);
      end
    end
    w = 0;
    while ((busy0 !== 1'b0 || ov0 !== 1'b0) && w < 40) begin
      tick; w++;
    end
    or0 = 1'b0;
    n_tests++;
    if (w >= 40) begin
      n_fail++; $display("FAIL b2b drain got busy=%b exp 0", busy0);
    end
  endtask

  task automatic test_reset_mid;
    logic [KW-1:0] ek;
    sel = 1'b0; use_aes = 1'b1;
    ek = expand_key(FIPS_KEY);
    block_in = FIPS_PT; ekey = ek; iv0 = 1'b1;
    tick;
    iv0 = 1'b0;
    repeat (4) tick;
    n_tests++;
    if (rk0 !== ek[128*5 +: 128] || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_round5_key got %h exp %h", rk0, ek[128*5 +: 128]);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({ir0, ov0, busy0, rl0} !== 4'b1000 || bo0 !== 128'h0 || rs0 !== 128'h0 || rk0 !== 128'h0) begin
      n_fail++;
      $display("FAIL async_reset got ir/ov/busy/last=%b%b%b%b out=%h state=%h exp 1000 zeros",
               ir0, ov0, busy0, rl0, bo0, rs0);
    end
    tick; tick;
    n_tests++;
    if ({ov0, busy0} !== 2'b00) begin
      n_fail++; $display("FAIL reset_held got ov/busy=%b%b exp 00", ov0, busy0);
    end
    reset = 1'b1;
    tick;
    run_block("fips_after_reset", FIPS_PT, ek, FIPS_CT, 0, 0, 1'b0);
  endtask

`ifdef AES_SEQ_ABORT_EN
  task automatic test_abort;
    logic [KW-1:0] ek;
    logic [127:0] blk;
    int seen;
    sel = 1'b0; use_aes = 1'b0;
    ek = stub_key(8'h00); blk = rand_blk();
    block_in = blk; ekey = ek; iv0 = 1'b1;
    tick;
    iv0 = 1'b0;
    repeat (9) tick;
    n_tests++;
    if (rl0 !== 1'b1) begin
      n_fail++; $display("FAIL abort_at_round10 last got %b exp 1", rl0);
    end
    abort0 = 1'b1;
    tick;
    abort0 = 1'b0;
    n_tests++;
    if ({ov0, busy0, ir0} !== 3'b001) begin
      n_fail++; $display("FAIL abort_final got ov/busy/ir=%b%b%b exp 001", ov0, busy0, ir0);
    end
    seen = 0;
    repeat (4) begin
      tick;
      if (ov0 !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_pulse got %0d valid cycles exp 0", seen);
    end
    abort0 = 1'b1; iv0 = 1'b1; block_in = rand_blk();
    tick;
    iv0 = 1'b0;
    n_tests++;
    if (busy0 !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_idle got busy=%b exp 1", busy0);
    end
    tick;
    abort0 = 1'b0;
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++; $display("FAIL abort_in_round got busy=%b exp 0", busy0);
    end
    use_aes = 1'b1;
    run_block("fips_after_abort", FIPS_PT, expand_key(FIPS_KEY), FIPS_CT, 0, 0, 1'b0);
  endtask
`endif

  // ---------------- main sequence and report ----------------
  initial begin
    iv0 = 1'b0; or0 = 1'b0; iv2 = 1'b0; or2 = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    abort0 = 1'b0; abort2 = 1'b0;
`endif
    use_aes = 1'b0; sel = 1'b0;
    block_in = '0; ekey = '0;
    build_sbox();
    tick; tick;
    test_reset();
    reset = 1'b1;
    tick;
    test_fips();
    test_stub(1'b0, 0);
    test_stub(1'b1, 2);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_SEQ_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL global_timeout reached at %0t exp finish earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
